// File: rtl/packet_demux.sv
// Dibit-serial packet demultiplexer: assembles bytes from 2-bit input, decodes a
// channel byte and big-endian address, then emits addressed payload bytes per channel.
module packet_demux #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_BYTES = 3,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [1:0]        axiid,
    output logic [NUM_CH-1:0] axiov,
    output logic [ADDR_W-1:0] addr_axiod,
    output logic [7:0]        data_axiod,
    output logic              pkt_done,
    output logic [15:0]       drop_count
);

    localparam int AW = 8 * ADDR_BYTES;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHAN    = 3'd1,
        ADDR    = 3'd2,
        PAYLOAD = 3'd3,
        DROP    = 3'd4,
        WAIT    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [5:0]         shift_q, shift_d;
    logic [1:0]         addr_idx_q, addr_idx_d;
    logic [AW-1:0]      addr_acc_q, addr_acc_d;
    logic [3:0]         ch_q, ch_d;
    logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
    logic [NUM_CH-1:0]  axiov_q, axiov_d;
    logic [ADDR_W-1:0]  addr_out_q, addr_out_d;
    logic [7:0]         data_q, data_d;
    logic               done_q, done_d;
    logic [15:0]        drop_q, drop_d;

    logic [7:0] full_byte;
    logic       byte_done;

    // shift_q always holds the last three dibits, so the fourth completes a byte
    assign full_byte = {shift_q, axiid};
    assign byte_done = axiiv && (cnt_q == 2'd3);

    always_comb begin
        state_d     = state_q;
        cnt_d       = 2'd0;
        shift_d     = shift_q;
        addr_idx_d  = addr_idx_q;
        addr_acc_d  = addr_acc_q;
        ch_d        = ch_q;
        next_addr_d = next_addr_q;
        axiov_d     = '0;
        addr_out_d  = addr_out_q;
        data_d      = data_q;
        done_d      = 1'b0;
        drop_d      = drop_q;

        if (axiiv) begin
            shift_d = {shift_q[3:0], axiid};
        end

        case (state_q)
            WAIT: begin
                if (!axiiv) state_d = IDLE;
            end
            IDLE: begin
                if (axiiv) begin
                    state_d    = CHAN;
                    cnt_d      = 2'd1;
                    addr_idx_d = 2'd0;
                end
            end
            CHAN, ADDR, PAYLOAD, DROP: begin
                if (!axiiv) begin
                    state_d = IDLE;
                    if (state_q == PAYLOAD) begin
                        done_d = 1'b1;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    if (byte_done) begin
                        case (state_q)
                            CHAN: begin
                                if ({1'b0, full_byte} < 9'(NUM_CH)) begin
                                    state_d = ADDR;
                                    ch_d    = full_byte[3:0];
                                end else begin
                                    state_d = DROP;
                                end
                            end
                            ADDR: begin
                                addr_acc_d = (addr_acc_q << 8) | AW'(full_byte);
                                addr_idx_d = addr_idx_q + 2'd1;
                                if (addr_idx_q == 2'(ADDR_BYTES - 1)) begin
                                    state_d     = PAYLOAD;
                                    next_addr_d = addr_acc_d[ADDR_W-1:0];
                                end
                            end
                            PAYLOAD: begin
                                axiov_d     = NUM_CH'(1) << ch_q;
                                data_d      = full_byte;
                                addr_out_d  = next_addr_q;
                                next_addr_d = next_addr_q + ADDR_W'(1);
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT;
            cnt_q       <= 2'd0;
            shift_q     <= 6'd0;
            addr_idx_q  <= 2'd0;
            addr_acc_q  <= '0;
            ch_q        <= 4'd0;
            next_addr_q <= '0;
            axiov_q     <= '0;
            addr_out_q  <= '0;
            data_q      <= 8'd0;
            done_q      <= 1'b0;
            drop_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_idx_q  <= addr_idx_d;
            addr_acc_q  <= addr_acc_d;
            ch_q        <= ch_d;
            next_addr_q <= next_addr_d;
            axiov_q     <= axiov_d;
            addr_out_q  <= addr_out_d;
            data_q      <= data_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    assign axiov      = axiov_q;
    assign addr_axiod = addr_out_q;
    assign data_axiod = data_q;
    assign pkt_done   = done_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_packet_demux.sv
// Directed bench for packet_demux: byte pulses are logged by a negedge monitor
// and compared against hand-computed expectations.
module tb_packet_demux;

    localparam int NUM_CH     = 2;
    localparam int ADDR_BYTES = 3;
    localparam int ADDR_W     = 17;
    localparam int W          = NUM_CH + ADDR_W + 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              axiiv = 1'b0;
    logic [1:0]        axiid = 2'd0;
    logic [NUM_CH-1:0] axiov;
    logic [ADDR_W-1:0] addr_axiod;
    logic [7:0]        data_axiod;
    logic              pkt_done;
    logic [15:0]       drop_count;

    packet_demux #(
        .NUM_CH(NUM_CH), .ADDR_BYTES(ADDR_BYTES), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(axiov), .addr_axiod(addr_axiod), .data_axiod(data_axiod),
        .pkt_done(pkt_done), .drop_count(drop_count)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: log every byte pulse and count pkt_done pulses
    logic [W-1:0] obs_q[$];
    int           obs_cyc[$];
    int           done_cnt;
    always @(negedge clk) begin
        if (axiov != '0) begin
            obs_q.push_back({axiov, addr_axiod, data_axiod});
            obs_cyc.push_back(cyc);
        end
        if (pkt_done) done_cnt = done_cnt + 1;
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;
    int obs_base;
    int done_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_dibit(input logic [1:0] d);
        axiiv = 1'b1;
        axiid = d;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 3; i >= 0; i--) send_dibit(b[2*i +: 2]);
    endtask

    task automatic send_hdr(input logic [7:0] ch, input logic [23:0] a);
        send_byte(ch);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic gap(input int n);
        axiiv = 1'b0;
        axiid = 2'd0;
        repeat (n) step();
    endtask

    task automatic begin_test();
        obs_base  = obs_q.size();
        done_base = done_cnt;
        exp_q.delete();
    endtask

    task automatic expect_pulse(input logic [NUM_CH-1:0] v, input logic [ADDR_W-1:0] a,
                                input logic [7:0] d);
        exp_q.push_back({v, a, d});
    endtask

    task automatic check_pulses(input string tag, input int exp_done, input bit check_gap);
        int n;
        n = obs_q.size() - obs_base;
        chk({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk({tag, "_byte"}, 32'(obs_q[obs_base + i]), 32'(exp_q[i]));
        if (check_gap)
            for (int i = 1; i < n; i++)
                chk({tag, "_gap"}, obs_cyc[obs_base + i] - obs_cyc[obs_base + i - 1], 4);
        chk({tag, "_done"}, done_cnt - done_base, exp_done);
    endtask

    initial begin
        // reset with axiiv low: everything zero, then release
        rst = 1'b1;
        repeat (3) step();
        chk("rst_axiov", axiov, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_data", data_axiod, 0);
        chk("rst_addr", addr_axiod, 0);
        chk("rst_drop", drop_count, 0);
        rst = 1'b0;
        step();

        // channel 1, three bytes, consecutive addresses
        begin_test();
        send_hdr(8'h01, 24'h0001FE);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        gap(3);
        expect_pulse(2'b10, 17'h001FE, 8'hAA);
        expect_pulse(2'b10, 17'h001FF, 8'hBB);
        expect_pulse(2'b10, 17'h00200, 8'hCC);
        check_pulses("ch1", 1, 1'b1);

        // channel 0, address wraps at 2^17
        begin_test();
        send_hdr(8'h00, 24'h01FFFF);
        send_byte(8'h11); send_byte(8'h22);
        gap(3);
        expect_pulse(2'b01, 17'h1FFFF, 8'h11);
        expect_pulse(2'b01, 17'h00000, 8'h22);
        check_pulses("wrap", 1, 1'b1);
        chk("wrap_drop", drop_count, 0);

        // invalid channel: whole packet dropped
        begin_test();
        send_hdr(8'h05, 24'h000000);
        for (int i = 0; i < 10; i++) send_byte(8'(i * 17 + 3));
        gap(3);
        check_pulses("badch", 0, 1'b0);
        chk("badch_drop", drop_count, 1);

        // runt then back-to-back packet after a one-cycle gap
        begin_test();
        send_byte(8'h00);
        send_byte(8'h12);
        gap(1);
        send_hdr(8'h01, 24'h000010);
        send_byte(8'h5A);
        gap(3);
        expect_pulse(2'b10, 17'h00010, 8'h5A);
        check_pulses("runt", 1, 1'b0);
        chk("runt_drop", drop_count, 2);

        // trailing partial byte is discarded
        begin_test();
        send_hdr(8'h00, 24'h000100);
        send_byte(8'h01); send_byte(8'h02);
        send_dibit(2'b11); send_dibit(2'b10);
        gap(3);
        expect_pulse(2'b01, 17'h00100, 8'h01);
        expect_pulse(2'b01, 17'h00101, 8'h02);
        check_pulses("partial", 1, 1'b1);

        // reset mid-payload with axiiv held high
        send_hdr(8'h01, 24'h000000);
        send_byte(8'h3C);
        send_dibit(2'b01); send_dibit(2'b10);
        begin_test();
        rst = 1'b1;
        send_dibit(2'b11);
        rst = 1'b0;
        chk("mid_rst_axiov", axiov, 0);
        chk("mid_rst_data", data_axiod, 0);
        chk("mid_rst_addr", addr_axiod, 0);
        chk("mid_rst_drop", drop_count, 0);
        for (int i = 0; i < 9; i++) send_dibit(2'(i));
        gap(1);
        send_hdr(8'h00, 24'h000005);
        send_byte(8'h77);
        gap(3);
        expect_pulse(2'b01, 17'h00005, 8'h77);
        check_pulses("after_rst", 1, 1'b0);
        chk("after_rst_drop", drop_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/packet_demux.md
PACKET_DEMUX -- requirements
Module: packet_demux

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 2, the number of payload channels (1..16).
REQ-002 The module SHALL have parameter ADDR_BYTES, default 3, the number of header address bytes (1..4).
REQ-003 The module SHALL have parameter ADDR_W, default 17, the output address width (<= 8*ADDR_BYTES).
REQ-004 The module SHALL use a single clock and a synchronous, active-high reset, ports as follows:
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 axiiv  input  1  input dibit valid; high for the whole packet, low between packets.
REQ-008 axiid  input  2  input dibit, MSB-first within each byte.
REQ-009 axiov  output  NUM_CH  one-hot byte valid; bit k set means the byte belongs to channel k.
REQ-010 addr_axiod  output  ADDR_W  write address of the current byte.
REQ-011 data_axiod  output  8  payload byte.
REQ-012 pkt_done  output  1  one-cycle pulse at the end of an accepted packet.
REQ-013 drop_count  output  16  count of rejected packets.

Function
REQ-014 Byte assembly SHALL shift in one dibit per axiiv-high cycle, MSB-first; four dibits form one byte.
REQ-015 Packet format SHALL be: 1 channel byte, then ADDR_BYTES address bytes (big-endian), then zero or more payload bytes.
REQ-016 The state machine SHALL have states IDLE, CHAN, ADDR, PAYLOAD, DROP, WAIT.
REQ-017 IDLE -> CHAN SHALL occur when axiiv=1; that cycle's dibit is the first bit pair of the channel byte.
REQ-018 CHAN -> ADDR SHALL occur when the channel byte completes with value < NUM_CH; CHAN -> DROP SHALL occur when the value is >= NUM_CH.
REQ-019 ADDR -> PAYLOAD SHALL occur when the last address byte completes; the base address is the low ADDR_W bits of the address field.
REQ-020 In PAYLOAD, each completed byte SHALL drive data_axiod, addr_axiod and the axiov bit for the channel for exactly one cycle, the cycle after its 4th dibit is sampled.
REQ-021 The first payload byte SHALL carry the base address; each later byte SHALL carry the previous address + 1, wrapping modulo 2^ADDR_W.
REQ-022 axiov SHALL be all-zero in every cycle without a completed payload byte; data_axiod and addr_axiod SHALL hold their last values.
REQ-023 A cycle with axiiv=0 in CHAN, ADDR, PAYLOAD or DROP SHALL end the packet and return the FSM to IDLE on the next edge.
REQ-024 A partial byte (1-3 dibits) at packet end SHALL be discarded and not output.
REQ-025 pkt_done SHALL pulse for one cycle, the cycle after axiiv falls, when the packet ends from PAYLOAD (including zero payload bytes).
REQ-026 drop_count SHALL increment by 1 when a packet ends from DROP, CHAN or ADDR (invalid channel or runt), and SHALL saturate at 0xFFFF.
REQ-027 In DROP, the FSM SHALL consume input until axiiv=0 and SHALL assert no axiov.
REQ-028 A byte completing in the same cycle that axiiv falls SHALL NOT occur, because completion requires axiiv=1; the completed byte is output even if axiiv is 0 in the following cycle.

Reset
REQ-029 On rst=1, the FSM SHALL enter WAIT, and axiov, pkt_done, data_axiod, addr_axiod, drop_count and the dibit counter SHALL all be 0.
REQ-030 WAIT SHALL go to IDLE on the first cycle with axiiv=0, so that a packet interrupted by reset is ignored entirely and causes no drop_count increment.
REQ-031 If axiiv=0 during reset release, WAIT SHALL go to IDLE one cycle after release.

Verification
REQ-032 NUM_CH=2, ADDR_BYTES=3, ADDR_W=17; send ch=0x01, addr=0x0001FE, payload AA BB CC -> axiov=2'b10 three times, 4 cycles apart; addr 0x001FE/0x001FF/0x00200; data AA/BB/CC; one pkt_done.
REQ-033 Send ch=0x00, addr=0x01FFFF, payload 11 22 -> axiov=2'b01 with addr 0x1FFFF then 0x00000 (wrap).
REQ-034 Send ch=0x05 with 10 payload bytes -> no axiov, no pkt_done; drop_count 0 -> 1.
REQ-035 Send ch=0x00, one address byte, then axiiv low (runt) -> drop_count +1, no pkt_done; a back-to-back valid packet after a 1-cycle gap decodes correctly.
REQ-036 Send a valid packet with 2 payload bytes + 2 extra dibits -> exactly 2 axiov pulses and 1 pkt_done.
REQ-037 Assert rst for 1 cycle mid-payload with axiiv held high -> outputs 0; no further axiov until axiiv falls; the next packet is decoded normally; drop_count stays 0.
